// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point round/normalize pipeline:
// rounding-mode encodings, flag bit positions and rounding decision helpers.
package fp_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  localparam int unsigned FlagNx = 0;
  localparam int unsigned FlagUf = 1;
  localparam int unsigned FlagOf = 2;

  // Increment decision for the kept LSB; unknown encodings fall back to RNE.
  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic l, input logic g,
                                     input logic r, input logic s);
    logic inc;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | r | s);
      RM_RUP:  inc = ~sign & (g | r | s);
      RM_RMM:  inc = g;
      default: inc = g & (l | r | s);
    endcase
    return inc;
  endfunction

  // On overflow: infinity when the mode rounds away from zero, else max finite.
  function automatic logic of_to_inf(input logic [2:0] rm, input logic sign);
    logic inf;
    case (rm)
      RM_RTZ:  inf = 1'b0;
      RM_RDN:  inf = sign;
      RM_RUP:  inf = ~sign;
      default: inf = 1'b1;
    endcase
    return inf;
  endfunction

endpackage

// File: rtl/leading_zero_counter.sv
// Counts leading zeros of i_data from the MSB; returns Width for an all-zero word.
module leading_zero_counter #(
  parameter int unsigned Width = 27
) (
  input  logic [Width-1:0]         i_data,
  output logic [$clog2(Width+1)-1:0] o_count_c
);
  localparam int unsigned CntW = $clog2(Width + 1);

  always_comb begin
    logic found;
    found     = 1'b0;
    o_count_c = CntW'(Width);
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (!found && i_data[i]) begin
        found     = 1'b1;
        o_count_c = CntW'(int'(Width) - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_round_normalize.sv
// Three-stage normalize / round / pack pipeline producing an IEEE-754 result
// with {OF, UF, NX} flags; a single advance enable stalls every stage together.
module fp_round_normalize
  import fp_pkg::*;
#(
  parameter int unsigned SizeMantissa = 23,
  parameter int unsigned SizeExponent = 8
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 sign_in,
  input  logic [SizeExponent+1:0]              exponent_in,
  input  logic [SizeMantissa+4:0]              mantissa_in,
  input  logic [2:0]                           rm,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [SizeExponent+SizeMantissa:0]   result,
  output logic [2:0]                           flags
);

  localparam int unsigned MantW = SizeMantissa + 5;
  localparam int unsigned NormW = SizeMantissa + 4;
  localparam int unsigned SigW  = SizeMantissa + 1;
  localparam int unsigned ExpW  = SizeExponent + 2;
  localparam int unsigned CntW  = $clog2(NormW + 1);
  localparam int unsigned ShW   = $clog2(MantW + 1);
  localparam int unsigned ResW  = 1 + SizeExponent + SizeMantissa;
  localparam logic [ExpW-1:0] ExpMax = ExpW'((1 << SizeExponent) - 1);

  logic r_v1, r_v2, r_v3;
  logic w_adv;

  assign w_adv    = ~r_v3 | out_ready;
  assign in_ready = w_adv;

  // ---------------- S1: normalize ----------------
  logic [ExpW:0]    w_e_ext;
  logic [ExpW:0]    w_e0;
  logic [MantW-1:0] w_m0;
  logic [CntW-1:0]  w_lz;
  logic             w_sub;
  logic [ExpW:0]    w_rdist;
  logic [ShW-1:0]   w_rsh;
  logic             w_drop;
  logic [NormW-1:0] w_rs;
  logic [ExpW:0]    w_em1;
  logic [CntW-1:0]  w_lsh;
  logic [NormW-1:0] w_ls;
  logic [ExpW:0]    w_e_ls;
  logic [NormW-1:0] w_m1;
  logic [ExpW-1:0]  w_e1;

  // A carry is folded in first so every later path sees {0, hidden, ...}.
  assign w_e_ext = {exponent_in[ExpW-1], exponent_in};
  assign w_e0    = mantissa_in[MantW-1] ? w_e_ext + (ExpW+1)'(1) : w_e_ext;
  assign w_m0    = mantissa_in[MantW-1]
                   ? {1'b0, mantissa_in[MantW-1:2], mantissa_in[1] | mantissa_in[0]}
                   : mantissa_in;

  leading_zero_counter #(.Width(NormW)) u_lzc (
    .i_data    (w_m0[NormW-1:0]),
    .o_count_c (w_lz)
  );

  assign w_sub   = w_e0[ExpW] | (w_e0 == '0);
  assign w_rdist = (ExpW+1)'(1) - w_e0;
  assign w_rsh   = (w_rdist > (ExpW+1)'(MantW)) ? ShW'(MantW) : w_rdist[ShW-1:0];
  assign w_drop  = |(w_m0 & ~({MantW{1'b1}} << w_rsh));
  assign w_rs    = NormW'(w_m0 >> w_rsh);

  assign w_em1   = w_e0 - (ExpW+1)'(1);
  assign w_lsh   = (w_em1 < (ExpW+1)'(w_lz)) ? CntW'(w_em1) : w_lz;
  assign w_ls    = w_m0[NormW-1:0] << w_lsh;
  assign w_e_ls  = w_e0 - (ExpW+1)'(w_lsh);

  always_comb begin
    w_m1 = w_ls;
    w_e1 = w_ls[NormW-1] ? ExpW'(w_e_ls) : '0;
    if (mantissa_in == '0) begin
      w_m1 = '0;
      w_e1 = '0;
    end else if (w_sub) begin
      w_m1 = {w_rs[NormW-1:1], w_rs[0] | w_drop};
      w_e1 = '0;
    end
  end

  // ---------------- S2: round ----------------
  logic             r_s1_sign;
  logic [ExpW-1:0]  r_s1_exp;
  logic [SigW-1:0]  r_s1_sig;
  logic [2:0]       r_s1_grs;
  logic [2:0]       r_s1_rm;
  logic             w_inc;
  logic [SigW:0]    w_sum;

  assign w_inc = round_inc(r_s1_rm, r_s1_sign, r_s1_sig[0],
                           r_s1_grs[2], r_s1_grs[1], r_s1_grs[0]);
  assign w_sum = {1'b0, r_s1_sig} + (SigW+1)'(w_inc);

  // ---------------- S3: post-round and pack ----------------
  logic             r_s2_sign;
  logic [ExpW-1:0]  r_s2_exp;
  logic [SigW:0]    r_s2_sum;
  logic [2:0]       r_s2_rm;
  logic             r_s2_nx;
  logic             r_s2_uf;
  logic [ExpW-1:0]  w_exp3;
  logic [SizeMantissa-1:0] w_frac3;
  logic             w_of;
  logic [ResW-1:0]  w_res3;
  logic [2:0]       w_flags3;

  always_comb begin
    w_exp3  = r_s2_exp;
    w_frac3 = r_s2_sum[SigW-2:0];
    if (r_s2_sum[SigW]) begin
      w_exp3  = r_s2_exp + ExpW'(1);
      w_frac3 = '0;
    end else if ((r_s2_exp == '0) && r_s2_sum[SigW-1]) begin
      w_exp3 = ExpW'(1);
    end
    w_of   = (w_exp3 >= ExpMax);
    w_res3 = {r_s2_sign, w_exp3[SizeExponent-1:0], w_frac3};
    if (w_of) begin
      if (of_to_inf(r_s2_rm, r_s2_sign)) begin
        w_res3 = {r_s2_sign, {SizeExponent{1'b1}}, {SizeMantissa{1'b0}}};
      end else begin
        w_res3 = {r_s2_sign, {(SizeExponent-1){1'b1}}, 1'b0, {SizeMantissa{1'b1}}};
      end
    end
    w_flags3         = '0;
    w_flags3[FlagOf] = w_of;
    w_flags3[FlagUf] = r_s2_uf;
    w_flags3[FlagNx] = r_s2_nx | w_of;
  end

  logic [ResW-1:0] r_result;
  logic [2:0]      r_flags;

  // Pipeline registers; all stages move together on the advance enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_exp  <= '0;
      r_s1_sig  <= '0;
      r_s1_grs  <= '0;
      r_s1_rm   <= '0;
      r_s2_sign <= 1'b0;
      r_s2_exp  <= '0;
      r_s2_sum  <= '0;
      r_s2_rm   <= '0;
      r_s2_nx   <= 1'b0;
      r_s2_uf   <= 1'b0;
      r_result  <= '0;
      r_flags   <= '0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (in_valid) begin
        r_s1_sign <= sign_in;
        r_s1_exp  <= w_e1;
        r_s1_sig  <= w_m1[NormW-1:3];
        r_s1_grs  <= w_m1[2:0];
        r_s1_rm   <= rm;
      end
      if (r_v1) begin
        r_s2_sign <= r_s1_sign;
        r_s2_exp  <= r_s1_exp;
        r_s2_sum  <= w_sum;
        r_s2_rm   <= r_s1_rm;
        r_s2_nx   <= |r_s1_grs;
        r_s2_uf   <= (r_s1_exp == '0) & (|r_s1_grs);
      end
      if (r_v2) begin
        r_result <= w_res3;
        r_flags  <= w_flags3;
      end
    end
  end

  assign out_valid = r_v3;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_fp_round_normalize.sv
// Scoreboard bench for fp_round_normalize: vector table, latency, backpressure
// and in-flight reset sequences.
module tb_fp_round_normalize;
  import fp_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [9:0]  exponent_in;
  logic [27:0] mantissa_in;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  fp_round_normalize #(.SizeMantissa(23), .SizeExponent(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign_in     (sign_in),
    .exponent_in (exponent_in),
    .mantissa_in (mantissa_in),
    .rm          (rm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .flags       (flags)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [27:0] mant;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;

  function automatic logic [27:0] mk(input logic c, input logic h,
                                     input logic [22:0] f, input logic [2:0] grs);
    return {c, h, f, grs};
  endfunction

  function automatic void add(input logic s, input int e, input logic [27:0] m,
                              input logic [2:0] r, input logic [31:0] res,
                              input logic [2:0] f);
    vec_t v;
    v.sign = s; v.exp = 10'(e); v.mant = m; v.rm = r; v.res = res; v.flg = f;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Output monitor: every transfer must match the oldest expected entry.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got %h want none", result);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_result", e.id), result, e.res);
        chk($sformatf("vec%0d_flags", e.id), 32'(flags), 32'(e.flg));
      end
    end
  end

  task automatic drive(input int id);
    sign_in     = vecs[id].sign;
    exponent_in = vecs[id].exp;
    mantissa_in = vecs[id].mant;
    rm          = vecs[id].rm;
    in_valid    = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int id);
    int   n;
    exp_t e;
    n = 0;
    drive(id);
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout vec%0d: got in_ready 0 want 1", id);
    end else begin
      e.res = vecs[id].res; e.flg = vecs[id].flg; e.id = id;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    @(posedge clock);
    #1;
  endtask

  // Empty pipeline, out_ready high: output must appear on the third cycle.
  task automatic latency(input int id);
    exp_t e;
    drive(id);
    @(negedge clock);
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    e.res = vecs[id].res; e.flg = vecs[id].flg; e.id = id;
    sb.push_back(e);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock) chk("lat_c1", 32'(out_valid), 32'd0);
    @(negedge clock) chk("lat_c2", 32'(out_valid), 32'd0);
    @(negedge clock) chk("lat_c3", 32'(out_valid), 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int   n_before;
    bit   done;
    logic [2:0] bp_ov [5];
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sign_in = 1'b0; exponent_in = '0; mantissa_in = '0; rm = '0;
    bp_ov = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    add(0, 127,  mk(0, 1, 23'h0, 3'b000), RM_RNE, 32'h3F800000, 3'b000);
    add(0, 127,  mk(0, 1, '1,    3'b100), RM_RNE, 32'h40000000, 3'b001);
    add(0, 127,  mk(0, 1, '1,    3'b100), RM_RTZ, 32'h3FFFFFFF, 3'b001);
    add(0, 254,  mk(1, 0, 23'h0, 3'b000), RM_RTZ, 32'h7F7FFFFF, 3'b101);
    add(0, 254,  mk(1, 0, 23'h0, 3'b000), RM_RNE, 32'h7F800000, 3'b101);
    add(0, -5,   mk(0, 1, 23'h0, 3'b000), RM_RNE, 32'h00020000, 3'b000);
    add(0, -5,   mk(0, 1, 23'h1, 3'b000), RM_RNE, 32'h00020000, 3'b011);
    add(0, -5,   mk(0, 1, 23'h1, 3'b000), RM_RUP, 32'h00020001, 3'b011);
    add(1, 127,  mk(0, 1, 23'h0, 3'b001), RM_RDN, 32'hBF800001, 3'b001);
    add(1, 127,  mk(0, 1, 23'h0, 3'b001), RM_RUP, 32'hBF800000, 3'b001);
    add(0, 127,  mk(0, 1, 23'h0, 3'b100), RM_RMM, 32'h3F800001, 3'b001);
    add(0, 127,  mk(0, 1, 23'h0, 3'b100), RM_RNE, 32'h3F800000, 3'b001);
    add(1, 50,   28'h0,                   RM_RNE, 32'h80000000, 3'b000);
    add(0, 127,  mk(0, 0, 23'h400000, 3'b000), RM_RNE, 32'h3F000000, 3'b000);
    add(0, 2,    mk(0, 0, 23'h100000, 3'b000), RM_RNE, 32'h00200000, 3'b000);
    add(0, 1,    mk(0, 0, '1,    3'b100), RM_RNE, 32'h00800000, 3'b011);
    add(1, 255,  mk(0, 1, 23'h0, 3'b000), RM_RUP, 32'hFF7FFFFF, 3'b101);
    add(1, 255,  mk(0, 1, 23'h0, 3'b000), RM_RDN, 32'hFF800000, 3'b101);
    add(0, -100, mk(0, 1, 23'h0, 3'b000), RM_RUP, 32'h00000001, 3'b011);
    add(0, -100, mk(0, 1, 23'h0, 3'b000), RM_RNE, 32'h00000000, 3'b011);
    add(0, 127,  mk(0, 1, '1,    3'b100), 3'b101, 32'h40000000, 3'b001);
    add(0, 0,    mk(0, 1, 23'h0, 3'b000), RM_RNE, 32'h00400000, 3'b000);
    add(0, 127,  mk(1, 1, 23'h0, 3'b000), RM_RNE, 32'h40400000, 3'b000);

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;

    latency(0);
    drain();

    // Table pass, back-to-back, consumer always ready
    for (int i = 0; i < vecs.size(); i++) send(i);
    in_valid = 1'b0;
    drain();

    // Table pass with random consumer backpressure
    done = 1'b0;
    fork
      begin
        for (int i = vecs.size() - 1; i >= 0; i--) send(i);
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clock);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Four operands against a consumer stalled for five cycles
    n_before = n_out;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(i);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clock);
          chk($sformatf("bp_out_valid_c%0d", c), 32'(out_valid), 32'(bp_ov[c]));
          chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'(!bp_ov[c]));
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_delivered", 32'(n_out - n_before), 32'd4);

    // Reset with three operands in flight
    for (int i = 5; i <= 7; i++) send(i);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    #1 chk("inflight_rst_async", 32'(out_valid), 32'd0);
    @(negedge clock);
    chk("inflight_rst_out_valid", 32'(out_valid), 32'd0);
    chk("inflight_rst_result", result, 32'd0);
    chk("inflight_rst_flags", 32'(flags), 32'd0);
    chk("inflight_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    n_before = n_out;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      chk($sformatf("post_rst_quiet_c%0d", c), 32'(out_valid), 32'd0);
    end
    @(posedge clock);
    #1;
    latency(3);
    drain();
    chk("post_rst_delivered", 32'(n_out - n_before), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_round_normalize.md
FP_ROUND_NORMALIZE -- requirements
Module: fp_round_normalize

Interface
REQ-001 SHALL have parameter SizeMantissa, default 23, stored fraction width.
REQ-002 SHALL have parameter SizeExponent, default 8, exponent field width.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, input operand valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts the operand this cycle.
REQ-007 SHALL have port sign_in, input, 1, result sign.
REQ-008 SHALL have port exponent_in, input, SizeExponent+2, signed biased exponent; may be <=0 or exceed the field range.
REQ-009 SHALL have port mantissa_in, input, SizeMantissa+5, packed {carry, hidden, fraction, G, R, S}.
REQ-010 SHALL have port rm, input, 3, RISC-V frm: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-011 SHALL have port out_valid, output, 1, result valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port result, output, 1+SizeExponent+SizeMantissa, packed IEEE-754 {sign, exponent, fraction}.
REQ-014 SHALL have port flags, output, 3, {OF, UF, NX}.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 normalize, S2 round, S3 post-round/pack; latency exactly 3 cycles with no stall.
REQ-016 SHALL use a global advance enable = !out_valid | out_ready; in_ready SHALL equal this enable; when low, all stages hold.
REQ-017 SHALL transfer on in_valid & in_ready and on out_valid & out_ready only; bubbles SHALL propagate as valid=0.
REQ-018 S1: carry=1 SHALL shift right 1, exponent+1, OR the dropped bit into S.
REQ-019 S1: carry=0 SHALL left-shift by min(leading zeros of {hidden..S}, exponent-1) and subtract the same from the exponent; exponent field 0 if the hidden bit stays 0 (subnormal).
REQ-020 S1: exponent_in<1 SHALL right-shift by 1-exponent_in, clamped to SizeMantissa+5, OR all dropped bits into S, set exponent 0.
REQ-021 S1: mantissa_in all zero SHALL produce {sign_in, 0, 0}, flags 000.
REQ-022 S2 increment, with L=fraction LSB: RNE G&(L|R|S); RTZ 0; RDN sign&(G|R|S); RUP !sign&(G|R|S); RMM G; rm 101-111 treated as RNE.
REQ-023 S3: fraction increment carry-out SHALL increment the exponent with fraction 0; a subnormal rounding up to hidden=1 SHALL set exponent 1.
REQ-024 S3: exponent >= 2^SizeExponent-1 SHALL set OF and NX; result infinity for RNE/RMM, RUP positive, RDN negative; else max finite (0x7F7FFFFF with sign at defaults).
REQ-025 NX SHALL be G|R|S after S1, or OF; UF SHALL be set when the pre-round exponent field is 0 and NX.

Reset
REQ-026 reset_n low SHALL immediately clear all stage valid bits; out_valid=0, result=0, flags=000, in_ready=1, regardless of in-flight operands.
REQ-027 After release, the first accepted operand SHALL appear 3 cycles later with no stale output.

Structure
REQ-028 SHALL place round-mode encodings (enum) and flag bit indices in shared package fp_pkg.
REQ-029 SHALL instantiate one sub-module, leading_zero_counter, parameterized by width, used in S1.

Verification
REQ-030 exponent_in=127, hidden=1, fraction 0, GRS 000, RNE -> result 0x3F800000, flags 000, out_valid exactly 3 cycles after accept.
REQ-031 exponent_in=127, fraction all ones, G=1 R=S=0, RNE -> 0x40000000, flags 001; same with RTZ -> 0x3FFFFFFF, flags 001.
REQ-032 exponent_in=254, carry=1, RTZ -> 0x7F7FFFFF, flags 101; RNE -> 0x7F800000, flags 101.
REQ-033 exponent_in=-5, hidden=1, GRS 000, RNE -> subnormal exponent field 0, UF=1 and NX=1 if set bits shifted out, else flags 000.
REQ-034 4 back-to-back operands with out_ready low for 5 cycles -> in_ready low while out_valid&!out_ready; all 4 results delivered in order, none lost or duplicated.
REQ-035 reset_n pulsed low with 3 operands in flight -> out_valid 0 during reset and no result for those operands after release.
